multicycle_alu: RTL and testbench

- Parametrised successor to the single-cycle 32-bit ALU, used by the datapath/control unit.
- Adds a registered result, a Start/Busy/Done handshake, and multi-cycle operations: shift-add multiply and variable-amount shifts.
- Keeps the FunSel op encoding, half/full width select, and write-enabled {Z,C,N,O} flags register.
- Control unit issues one operation, waits for Done, then reads ALUOut and FlagsOut.

---
 rtl/multicycle_alu.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 126 ++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with a Start/Busy/Done handshake.
//   Mode=0 runs the single-cycle op group in one EXEC cycle.
//   Mode=1 runs a shift-add multiply (WIDTH cycles) or a variable shift
//   (one bit per cycle).
// Ports:
//   Clock, Reset (async, active-low)
//   Start, Mode, FunSel[4:0], WF, A, B  - request; latched when idle
//   ALUOut, FlagsOut {Z,C,N,O}          - registered result and flags
//   Busy (EXEC in progress), Done (one-cycle result-valid pulse)
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Mode,
  input  logic [4:0]       FunSel,
  input  logic             WF,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut,
  output logic             Busy,
  output logic             Done
);

  localparam int HALF = WIDTH / 2;
  localparam int SHW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, FINISH} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [4:0]         fsel_q;
  logic               mode_q, wf_q;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   sh;

  logic [WIDTH-1:0]   a_in, b_in;
  logic [SHW-1:0]     amt;
  logic               last;
  logic               c_in;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   sh_step;
  logic               sh_out;
  logic [WIDTH:0]     add_w, adc_w, sub_w;
  logic [WIDTH-1:0]   res_raw, res_ext;
  logic               c_new, c_upd, o_new, o_upd;
  logic [3:0]         flags_new;

  function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  assign a_in = FunSel[4] ? A : sext_half(A);
  assign b_in = FunSel[4] ? B : sext_half(B);
  assign amt  = b_q[SHW-1:0];
  assign c_in = FlagsOut[2];

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE:    if (Start) state_next = EXEC;
      EXEC: begin
        Busy = 1'b1;
        if (last) state_next = FINISH;
      end
      FINISH: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Final EXEC cycle: single-cycle ops always; MULU after WIDTH steps;
  // shifts after max(amt,1) steps.
  always_comb begin
    if (!mode_q)                  last = 1'b1;
    else if (fsel_q[1:0] == 2'b00) last = (cnt == SHW'(WIDTH - 1));
    else                          last = (amt == '0) || (cnt == amt - SHW'(1));
  end

  // One radix-2 multiply step and one single-bit variable-shift step
  always_comb begin
    acc_step = acc + (mplier[0] ? mcand : '0);
    sh_step  = sh;
    sh_out   = 1'b0;
    case (fsel_q[1:0])
      2'b01: begin sh_step = {sh[WIDTH-2:0], 1'b0};       sh_out = sh[WIDTH-1]; end
      2'b10: begin sh_step = {1'b0, sh[WIDTH-1:1]};       sh_out = sh[0];       end
      2'b11: begin sh_step = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_out = sh[0];      end
      default: ;
    endcase
  end

  // Result and flag computation, consumed on the last EXEC cycle
  always_comb begin
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    adc_w   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_in};
    sub_w   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    res_raw = a_q;
    c_new   = 1'b0;
    c_upd   = 1'b0;
    o_new   = 1'b0;
    o_upd   = 1'b0;
    if (!mode_q) begin
      case (fsel_q[3:0])
        4'h0: res_raw = a_q;
        4'h1: res_raw = b_q;
        4'h2: res_raw = ~a_q;
        4'h3: res_raw = ~b_q;
        4'h4: begin {c_new, res_raw} = add_w; c_upd = 1'b1; o_upd = 1'b1; end
        4'h5: begin {c_new, res_raw} = adc_w; c_upd = 1'b1; o_upd = 1'b1; end
        4'h6: begin {c_new, res_raw} = sub_w; c_upd = 1'b1; o_upd = 1'b1; end
        4'h7: res_raw = a_q & b_q;
        4'h8: res_raw = a_q | b_q;
        4'h9: res_raw = a_q ^ b_q;
        4'hA: res_raw = ~(a_q & b_q);
        4'hB: begin res_raw = {a_q[WIDTH-2:0], 1'b0};       c_new = a_q[WIDTH-1]; c_upd = 1'b1; end
        4'hC: begin res_raw = {1'b0, a_q[WIDTH-1:1]};       c_new = a_q[0];       c_upd = 1'b1; end
        4'hD: begin res_raw = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; c_new = a_q[0];     c_upd = 1'b1; end
        4'hE: begin res_raw = {a_q[WIDTH-2:0], c_in};       c_new = a_q[WIDTH-1]; c_upd = 1'b1; end
        4'hF: begin res_raw = {c_in, a_q[WIDTH-1:1]};       c_new = a_q[0];       c_upd = 1'b1; end
        default: ;
      endcase
    end else if (fsel_q[1:0] == 2'b00) begin
      res_raw = acc_step[WIDTH-1:0];
      c_new   = |acc_step[2*WIDTH-1:WIDTH];
      c_upd   = 1'b1;
    end else if (amt == '0) begin
      res_raw = sh;
    end else begin
      res_raw = sh_step;
      c_new   = sh_out;
      c_upd   = 1'b1;
    end

    // Half-width ops deliver the lower HALF of the result sign-extended,
    // so N/O observe the extended sign bit.
    res_ext = fsel_q[4] ? res_raw : sext_half(res_raw);

    if (mode_q == 1'b0 && fsel_q[3:0] == 4'h6)
      o_new = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_ext[WIDTH-1] == b_q[WIDTH-1]);
    else
      o_new = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_ext[WIDTH-1] != a_q[WIDTH-1]);

    flags_new = {(res_ext == '0),
                 c_upd ? c_new : FlagsOut[2],
                 res_ext[WIDTH-1],
                 o_upd ? o_new : FlagsOut[0]};
  end

  // Operand latches, iteration registers, result and flags
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      fsel_q   <= '0;
      mode_q   <= 1'b0;
      wf_q     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sh       <= '0;
      ALUOut   <= '0;
      FlagsOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q    <= a_in;
            b_q    <= b_in;
            fsel_q <= FunSel;
            mode_q <= Mode;
            wf_q   <= WF;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_in};
            mplier <= b_in;
            sh     <= a_in;
          end
        end
        EXEC: begin
          cnt    <= cnt + SHW'(1);
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          sh     <= sh_step;
          if (last) begin
            ALUOut <= res_ext;
            if (wf_q) FlagsOut <= flags_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed checks of multicycle_alu (WIDTH=32).
module tb_multicycle_alu;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Mode;
  logic [4:0]  FunSel;
  logic        WF;
  logic [31:0] A, B;
  logic [31:0] ALUOut;
  logic [3:0]  FlagsOut;
  logic        Busy, Done;

  int checks   = 0;
  int failures = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Mode     (Mode),
    .FunSel   (FunSel),
    .WF       (WF),
    .A        (A),
    .B        (B),
    .ALUOut   (ALUOut),
    .FlagsOut (FlagsOut),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Issue one op at a negedge, count cycles to Done, check result, flags,
  // Busy span and the Done pulse width. poke drives a Start mid-operation.
  task automatic run_op(input string tag, input logic m, input logic [4:0] fs,
                        input logic wf, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_out,
                        input logic [3:0] exp_flags, input logic poke);
    int cyc;
    int busy_n;
    @(negedge Clock);
    Mode = m; FunSel = fs; WF = wf; A = a; B = b; Start = 1'b1;
    @(negedge Clock);
    Start  = 1'b0;
    cyc    = 1;
    busy_n = 0;
    while (!Done && cyc < 100) begin
      if (Busy) busy_n++;
      if (poke && cyc == 10) begin
        Mode = 1'b0; FunSel = 5'b1_0100; WF = 1'b1;
        A = 32'h0000_0003; B = 32'h0000_0005; Start = 1'b1;
      end
      if (poke && cyc == 11) Start = 1'b0;
      @(negedge Clock);
      cyc++;
    end
    chk({tag, "_lat"},   cyc, exp_lat);
    chk({tag, "_busy"},  busy_n, exp_lat - 1);
    chk({tag, "_out"},   ALUOut, exp_out);
    chk({tag, "_flags"}, {28'd0, FlagsOut}, {28'd0, exp_flags});
    chk({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
    @(negedge Clock);
    chk({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    chk({tag, "_idle"},       {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Mode = 1'b0; FunSel = '0; WF = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    chk("rst_out",   ALUOut, 32'd0);
    chk("rst_flags", {28'd0, FlagsOut}, 32'd0);
    chk("rst_busy",  {31'd0, Busy}, 32'd0);
    chk("rst_done",  {31'd0, Done}, 32'd0);
    Reset = 1'b1;

    run_op("add_wrap",  1'b0, 5'b1_0100, 1'b1, 32'hFFFF_FFFF, 32'h1, 2, 32'h0000_0000, 4'b1100, 1'b0);
    run_op("sub_ovf",   1'b0, 5'b1_0110, 1'b1, 32'h8000_0000, 32'h1, 2, 32'h7FFF_FFFF, 4'b0101, 1'b0);
    run_op("sub_nowf",  1'b0, 5'b1_0110, 1'b0, 32'h8000_0000, 32'h1, 2, 32'h7FFF_FFFF, 4'b0101, 1'b0);
    run_op("add_nowf",  1'b0, 5'b1_0100, 1'b0, 32'hFFFF_FFFF, 32'h1, 2, 32'h0000_0000, 4'b0101, 1'b0);
    run_op("adc_c1",    1'b0, 5'b1_0101, 1'b1, 32'h1,         32'h2, 2, 32'h0000_0004, 4'b0000, 1'b0);
    run_op("lsl1",      1'b0, 5'b1_1011, 1'b1, 32'h8000_0001, 32'h0, 2, 32'h0000_0002, 4'b0100, 1'b0);
    run_op("rrc_c1",    1'b0, 5'b1_1111, 1'b1, 32'h0000_0002, 32'h0, 2, 32'h8000_0001, 4'b0010, 1'b0);
    run_op("mulu_hi",   1'b1, 5'b1_0000, 1'b1, 32'h0001_0000, 32'h0001_0000, 33, 32'h0000_0000, 4'b1100, 1'b1);
    run_op("mulu_ffff", 1'b1, 5'b1_0000, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 33, 32'hFFFE_0001, 4'b0010, 1'b0);
    run_op("sub_setc",  1'b0, 5'b1_0110, 1'b1, 32'h8000_0000, 32'h1, 2, 32'h7FFF_FFFF, 4'b0101, 1'b0);
    run_op("asr4",      1'b1, 5'b1_0011, 1'b1, 32'h8000_0000, 32'd4, 5, 32'hF800_0000, 4'b0011, 1'b0);
    run_op("sub_setc2", 1'b0, 5'b1_0110, 1'b1, 32'h8000_0000, 32'h1, 2, 32'h7FFF_FFFF, 4'b0101, 1'b0);
    run_op("asr0",      1'b1, 5'b1_0011, 1'b1, 32'h8000_0000, 32'd0, 2, 32'h8000_0000, 4'b0111, 1'b0);
    run_op("shr5",      1'b1, 5'b1_0010, 1'b1, 32'h0000_00F0, 32'd5, 6, 32'h0000_0007, 4'b0101, 1'b0);
    run_op("shl31",     1'b1, 5'b1_1101, 1'b1, 32'h0000_0003, 32'd31, 32, 32'h8000_0000, 4'b0111, 1'b0);
    run_op("half_add",  1'b0, 5'b0_0100, 1'b1, 32'h0000_7FFF, 32'h1, 2, 32'hFFFF_8000, 4'b0011, 1'b0);

    // Asynchronous reset in the middle of a multiply
    @(negedge Clock);
    Mode = 1'b1; FunSel = 5'b1_0000; WF = 1'b1; A = 32'd5; B = 32'd7; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    chk("mid_busy", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_out",   ALUOut, 32'd0);
    chk("arst_flags", {28'd0, FlagsOut}, 32'd0);
    chk("arst_busy",  {31'd0, Busy}, 32'd0);
    chk("arst_done",  {31'd0, Done}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    run_op("post_rst_sub", 1'b0, 5'b1_0110, 1'b1, 32'h1, 32'h2, 2, 32'hFFFF_FFFF, 4'b0010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
